// File: rtl/redundancy_expander.sv
// redundancy_expander: rebuilds a full lowered LIFM column from one dense
// column and its mapping-table (MT) column, LANES output positions per cycle.
// Output word j takes the dense word at the lowest set bit of MT entry j, or
// zero when the entry is empty.
// Optional build macro: REDUNDANCY_EXPANDER_ONEHOT_CHECK_EN enables the
// multi-bit MT entry check driving mt_err; without it mt_err is tied to 0.
//
// Handshakes: a column transfers on the input side at a posedge where
// enable_in=1 and in_ready=1; the output column transfers at a posedge where
// valid=1 and out_ready=1. valid and lifm_column/mt_err stay stable until that
// transfer. in_ready and valid are never high together, so accept and release
// cannot coincide.
module redundancy_expander #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 16,
  parameter int LANES      = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable_in,
  output logic                             in_ready,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0] dlifm_column,
  input  logic [STEP_RANGE*STEP_RANGE-1:0] mt_column,
  output logic                             valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] lifm_column,
  output logic                             mt_err,
  output logic [1:0]                       state_dbg
);

  localparam int N  = STEP_RANGE / LANES;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(STEP_RANGE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           lane_cnt_q;
  logic [WORD_WIDTH-1:0]   dense_q [STEP_RANGE];
  logic [STEP_RANGE-1:0]   mt_q    [STEP_RANGE];
  logic [WORD_WIDTH-1:0]   out_buf [STEP_RANGE];
  logic [PW-1:0]           lane_idx   [LANES];
  logic [STEP_RANGE-1:0]   lane_entry [LANES];
  logic [WORD_WIDTH-1:0]   lane_word  [LANES];
  logic                    last_lane;

  assign last_lane = (lane_cnt_q == CW'(N - 1));
  assign in_ready  = (state_q == IDLE);
  assign valid     = (state_q == OUTPUT);
  assign state_dbg = state_q;

  // State register; reset overrides everything, discarding any in-flight column.
  always_ff @(posedge clk) begin
    if (reset_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic for accept -> expand -> hold-until-taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_in) state_d = EXPAND;
      EXPAND:  if (last_lane) state_d = OUTPUT;
      OUTPUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-lane selection: lowest set bit of the MT entry picks the dense word.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_idx[k]   = PW'(int'(lane_cnt_q) * LANES + k);
      lane_entry[k] = mt_q[lane_idx[k]];
      lane_word[k]  = '0;
      // Scan high to low so the lowest set bit is the last (winning) assignment.
      for (int i = STEP_RANGE - 1; i >= 0; i--) begin
        if (lane_entry[k][i]) lane_word[k] = dense_q[i];
      end
    end
  end

  // Column capture, lane counter and slice-wise write of the output buffer.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      lane_cnt_q <= '0;
      for (int i = 0; i < STEP_RANGE; i++) begin
        dense_q[i] <= '0;
        mt_q[i]    <= '0;
        out_buf[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_in) begin
            lane_cnt_q <= '0;
            for (int i = 0; i < STEP_RANGE; i++) begin
              dense_q[i] <= dlifm_column[i*WORD_WIDTH +: WORD_WIDTH];
              mt_q[i]    <= mt_column[i*STEP_RANGE +: STEP_RANGE];
            end
          end
        end
        EXPAND: begin
          lane_cnt_q <= lane_cnt_q + CW'(1);
          for (int k = 0; k < LANES; k++) begin
            out_buf[lane_idx[k]] <= lane_word[k];
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten the output buffer onto the packed column port.
  for (genvar g = 0; g < STEP_RANGE; g++) begin : g_pack
    assign lifm_column[g*WORD_WIDTH +: WORD_WIDTH] = out_buf[g];
  end

`ifdef REDUNDANCY_EXPANDER_ONEHOT_CHECK_EN
  logic lane_err;
  logic mt_err_q;

  // An entry with more than one bit set has a nonzero value after clearing its lowest bit.
  always_comb begin
    lane_err = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if ((lane_entry[k] & (lane_entry[k] - STEP_RANGE'(1))) != '0) lane_err = 1'b1;
    end
  end

  // Sticky error flag for the column being expanded; cleared on each accept.
  always_ff @(posedge clk) begin
    if (reset_n)                            mt_err_q <= 1'b0;
    else if (state_q == IDLE && enable_in)  mt_err_q <= 1'b0;
    else if (state_q == EXPAND && lane_err) mt_err_q <= 1'b1;
  end

  assign mt_err = mt_err_q;
`else
  assign mt_err = 1'b0;
`endif

endmodule

// File: tb/tb_redundancy_expander.sv
// Directed testbench for redundancy_expander (WORD_WIDTH=8, STEP_RANGE=16, LANES=4).
module tb_redundancy_expander;

  localparam int W  = 8;
  localparam int SR = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable_in;
  logic              in_ready;
  logic [W*SR-1:0]   dlifm_column;
  logic [SR*SR-1:0]  mt_column;
  logic              valid;
  logic              out_ready;
  logic [W*SR-1:0]   lifm_column;
  logic              mt_err;
  logic [1:0]        state_dbg;

  int vectors = 0;
  int miscompares = 0;

`ifdef REDUNDANCY_EXPANDER_ONEHOT_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  redundancy_expander dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable_in    (enable_in),
    .in_ready     (in_ready),
    .dlifm_column (dlifm_column),
    .mt_column    (mt_column),
    .valid        (valid),
    .out_ready    (out_ready),
    .lifm_column  (lifm_column),
    .mt_err       (mt_err),
    .state_dbg    (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W*SR-1:0] obs, input logic [W*SR-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a column once in_ready is seen; returns just after the accept edge.
  task automatic send(input logic [W*SR-1:0] d, input logic [SR*SR-1:0] m);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_in_ready", {127'b0, in_ready}, 1);
    dlifm_column = d;
    mt_column    = m;
    enable_in    = 1'b1;
    tick();
    enable_in    = 1'b0;
  endtask

  // Counts edges after the accept until valid appears (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Reference expansion: first (lowest) set bit of each entry selects the word.
  function automatic logic [W*SR-1:0] golden(input logic [W*SR-1:0] d, input logic [SR*SR-1:0] m);
    logic [W*SR-1:0] r;
    logic [SR-1:0]   e;
    r = '0;
    for (int j = 0; j < SR; j++) begin
      e = m[j*SR +: SR];
      for (int i = 0; i < SR; i++) begin
        if (e[i]) begin
          r[j*W +: W] = d[i*W +: W];
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic golden_err(input logic [SR*SR-1:0] m);
    logic [SR-1:0] e;
    int pc;
    logic r;
    r = 1'b0;
    for (int j = 0; j < SR; j++) begin
      e = m[j*SR +: SR];
      pc = 0;
      for (int i = 0; i < SR; i++) if (e[i]) pc++;
      if (pc > 1) r = 1'b1;
    end
    return r & ERR_EN;
  endfunction

  initial begin
    logic [W*SR-1:0]  id_d, bc_d, mb_d, sd [3];
    logic [SR*SR-1:0] id_m, bc_m, mb_m, sm [3];
    logic [W*SR-1:0]  bc_exp;
    logic             seen;
    int               cyc;

    // Directed column set
    for (int j = 0; j < SR; j++) begin
      id_d[j*W +: W]   = 8'(j + 1);
      id_m[j*SR +: SR] = 16'(1) << j;
      bc_d[j*W +: W]   = (j == 0) ? 8'hA5 : 8'(8'h50 + j);
      bc_m[j*SR +: SR] = (j < 8) ? 16'h0001 : 16'h0000;
      mb_d[j*W +: W]   = 8'h77;
      mb_m[j*SR +: SR] = (j == 3) ? 16'h0006 : 16'h0000;
    end
    mb_d[1*W +: W] = 8'h11;
    mb_d[2*W +: W] = 8'h22;
    bc_exp = 128'h0000000000000000A5A5A5A5A5A5A5A5;

    // Streaming columns: mix of one-hot, empty and multi-bit entries
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < SR; j++) begin
        sd[c][j*W +: W] = 8'($urandom_range(0, 255));
        if (j % 5 == 0)      sm[c][j*SR +: SR] = 16'h0000;
        else if (j % 7 == 3) sm[c][j*SR +: SR] = 16'($urandom_range(1, 65535)) | 16'h8001;
        else                 sm[c][j*SR +: SR] = 16'(1) << $urandom_range(0, 15);
      end
    end

    // Reset
    reset_n = 1'b1; enable_in = 1'b0; out_ready = 1'b1;
    dlifm_column = '0; mt_column = '0;
    tick(); tick();
    reset_n = 1'b0;
    check("rst_valid", {127'b0, valid}, 0);
    check("rst_in_ready", {127'b0, in_ready}, 1);
    check("rst_lifm", lifm_column, 0);
    check("rst_mt_err", {127'b0, mt_err}, 0);

    // Reset pulse in the second EXPAND cycle discards the column
    send(id_d, id_m);
    tick();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    check("midrst_in_ready", {127'b0, in_ready}, 1);
    check("midrst_lifm", lifm_column, 0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (valid) seen = 1'b1;
      tick();
    end
    check("midrst_no_valid", {127'b0, seen}, 0);

    // Identity mapping, latency and release
    send(id_d, id_m);
    wait_valid(cyc);
    check("id_latency", 128'(cyc), 4);
    check("id_lifm", lifm_column, 128'h100F0E0D0C0B0A090807060504030201);
    check("id_mt_err", {127'b0, mt_err}, 0);
    check("id_in_ready", {127'b0, in_ready}, 0);
    tick();
    check("id_rel_valid", {127'b0, valid}, 0);
    check("id_rel_in_ready", {127'b0, in_ready}, 1);

    // Broadcast + zero fill, held under back-pressure
    out_ready = 1'b0;
    send(bc_d, bc_m);
    wait_valid(cyc);
    check("bc_latency", 128'(cyc), 4);
    check("bc_lifm", lifm_column, bc_exp);
    for (int c = 0; c < 10; c++) begin
      enable_in = ~enable_in;
      dlifm_column = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("bp_valid", {127'b0, valid}, 1);
      check("bp_in_ready", {127'b0, in_ready}, 0);
      check("bp_lifm", lifm_column, bc_exp);
    end
    enable_in = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_rel_valid", {127'b0, valid}, 0);
    check("bp_rel_in_ready", {127'b0, in_ready}, 1);

    // Multi-bit entry: lowest set bit wins
    send(mb_d, mb_m);
    wait_valid(cyc);
    check("mb_latency", 128'(cyc), 4);
    check("mb_lifm", lifm_column, 128'h00000000000000000000000011000000);
    check("mb_mt_err", {127'b0, mt_err}, {127'b0, ERR_EN});
    tick();
    // mt_err clears on the next accept
    send(id_d, id_m);
    check("mb_err_clear", {127'b0, mt_err}, 0);
    wait_valid(cyc);
    check("id2_lifm", lifm_column, 128'h100F0E0D0C0B0A090807060504030201);
    tick();

    // Streaming: enable_in held high, accepts six cycles apart
    dlifm_column = sd[0];
    mt_column    = sm[0];
    enable_in    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("st_in_ready_pre", {127'b0, in_ready}, 1);
      tick();
      check("st_accepted", {127'b0, in_ready}, 0);
      if (c < 2) begin
        dlifm_column = sd[c+1];
        mt_column    = sm[c+1];
      end else begin
        enable_in = 1'b0;
      end
      wait_valid(cyc);
      check("st_latency", 128'(cyc), 4);
      check("st_lifm", lifm_column, golden(sd[c], sm[c]));
      check("st_mt_err", {127'b0, mt_err}, {127'b0, golden_err(sm[c])});
      tick();
      check("st_rel_valid", {127'b0, valid}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/redundancy_expander.md
Name: redundancy_expander

Overview:
- Inverse of the redundancy controller. Takes one dense LIFM column plus its mapping-table (MT) column and rebuilds the full lowered LIFM column.
- Each output position receives the dense word selected by its MT entry. Positions with an all-zero entry receive zero.
- Sits between the dense-IFM buffer and the PE array feed.
- Expansion is time-multiplexed over LANES positions per cycle. Valid/ready handshakes on both sides.

Parameters:
- WORD_WIDTH, 8, bitwidth of one activation word.
- STEP_RANGE, 16, words per column; also the number of MT entries, each STEP_RANGE bits.
- LANES, 4, output positions expanded per cycle; must divide STEP_RANGE.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset_n  input  1  synchronous active-high reset. Name kept for codebase consistency; asserted = 1.
- enable_in  input  1  input valid; a column is offered.
- in_ready  output  1  block can accept a column.
- dlifm_column  input  WORD_WIDTH*STEP_RANGE  dense column; word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- mt_column  input  STEP_RANGE*STEP_RANGE  MT column; entry j at bits [j*STEP_RANGE +: STEP_RANGE]; bit i of entry j set means output j takes dense word i.
- valid  output  1  lifm_column holds a complete expanded column.
- out_ready  input  1  downstream accepts the output.
- lifm_column  output  WORD_WIDTH*STEP_RANGE  expanded column, same packing as the input.
- mt_err  output  1  at least one MT entry of the current column had more than one bit set.

Behaviour:
- Reset (reset_n=1 at posedge):
  - state=IDLE, in_ready=1, valid=0.
  - lifm_column=0, mt_err=0.
  - Internal buffers and lane counter cleared.
  - Reset has priority over every event, including mid-EXPAND and mid-OUTPUT. The in-flight column is discarded.
- N = STEP_RANGE/LANES; lane counter is ceil(log2(N+1)) bits.
- IDLE:
  - in_ready=1, valid=0.
  - On enable_in=1, register dlifm_column and mt_column, clear mt_err, lane_cnt=0, go to EXPAND.
- EXPAND (in_ready=0):
  - Each cycle, for p = lane_cnt*LANES+k (k = 0..LANES-1), out_buf word p = dense word at the lowest set bit index of MT entry p, or 0 if the entry is all-zero.
  - Set mt_err if any processed entry has popcount > 1.
  - Increment lane_cnt. After the cycle with lane_cnt=N-1, go to OUTPUT.
  - Only the lane slice being written changes; other words hold.
- OUTPUT:
  - valid=1; lifm_column and mt_err are stable while valid=1 and out_ready=0.
  - enable_in is ignored (in_ready=0).
  - On out_ready=1, go to IDLE: valid=0 and in_ready=1 the next cycle.
  - lifm_column keeps its last value until the next column overwrites the slices.
- Latency:
  - Column accepted at posedge T → valid=1 from posedge T+N+1.
  - Throughput is one column per N+2 cycles with out_ready held at 1.
- No back-to-back accept in OUTPUT: the simultaneous out_ready and enable_in case is not allowed by construction. The new column is accepted in IDLE.
- Widths: all selection is muxing, no arithmetic. Lane counter wrap is impossible because the state exits at N-1.

Optional Feature:
- Macro: REDUNDANCY_EXPANDER_ONEHOT_CHECK_EN.
- Defined: popcount check active; mt_err behaves as above.
- Undefined: no popcount logic; mt_err tied to 0. Lowest-set-bit priority selection is unchanged.

Test Plan (STEP_RANGE=16, LANES=4, WORD_WIDTH=8, N=4):
- Reset: hold reset_n=1 2 cycles, then 0 → valid=0, in_ready=1, lifm_column=0, mt_err=0. Pulse reset_n=1 in the 2nd EXPAND cycle → back to IDLE, valid never rises.
- Identity: entry j=1<<j, dense word j=j+1, accepted at T → valid=1 at T+5; word j = j+1 for j = 0..15; mt_err=0.
- Broadcast and zero fill: entries 0..7=0x0001, entries 8..15=0x0000, dense word 0=0xA5 → words 0..7=0xA5, words 8..15=0x00.
- Back-pressure: out_ready=0 for 10 cycles after valid; toggle enable_in and dlifm_column → valid stays 1, lifm_column unchanged, in_ready=0. Set out_ready=1 → valid=0 next cycle, in_ready=1; the next column is accepted correctly.
- Multi-bit entry: entry 3=0x0006, dense word 1=0x11, word 2=0x22 → word 3=0x11. With the macro, mt_err=1; without it, mt_err=0. mt_err clears on the next accept.
- Streaming: 3 columns with enable_in held 1 and out_ready=1 → accepts at T, T+6, T+12; each output matches its golden expansion.
